// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the iterative divider.
// Optional early exit is enabled by defining DIV_EARLY_EXIT_EN.
package div_pkg;
  localparam int DIV_W  = 32;
  localparam int DIV_CW = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
// The compare is one bit wider than the divisor so no carry is lost.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {rem_i, dvd_msb_i};
  assign diff  = trial - {1'b0, dvs_i};
  assign q_o   = (trial >= {1'b0, dvs_i});
  assign rem_o = q_o ? diff[W-1:0] : trial[W-1:0];
endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with valid/ready, cancel and hold.
// Define DIV_EARLY_EXIT_EN to skip the step loop when y==0 or |x|<|y|.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic sq_q, sq_d;
  logic sr_q, sr_d;
  logic yz_q, yz_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign x_abs = (div_signed & x[WIDTH-1]) ? -x : x;
  assign y_abs = (div_signed & y[WIDTH-1]) ? -y : y;

  div_step #(.W(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    yz_d    = yz_q;
    s_d     = s_q;
    r_d     = r_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_valid) begin
          state_d = DIV_CALC;
          cnt_d   = '0;
          dvd_d   = x_abs;
          rem_d   = '0;
          dvs_d   = y_abs;
          sq_d    = div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
          sr_d    = div_signed & x[WIDTH-1];
          yz_d    = (y == '0);
`ifdef DIV_EARLY_EXIT_EN
          // Preload the final quotient/remainder; only the fix-up edge remains
          if ((y == '0) || (x_abs < y_abs)) begin
            cnt_d = LAST;
            dvd_d = '0;
            rem_d = x_abs;
          end
`else
`endif
        end
      end
      DIV_CALC: begin
        if (cnt_q == LAST) begin
          state_d = DIV_DONE;
          s_d = yz_q ? '1 : (sq_q ? -dvd_q : dvd_q);
          r_d = sr_q ? -rem_q : rem_q;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV_DONE: begin
        if (res_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (cancel) state_d = DIV_IDLE;
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      yz_q    <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      yz_q    <= yz_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign div_ready = (state_q == DIV_IDLE);
  assign res_valid = (state_q == DIV_DONE);
  assign s = s_q;
  assign r = r_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed-vector and corner-sequence bench for div_iter.
// Assumes the default build (DIV_EARLY_EXIT_EN undefined).
module tb_div_iter;
  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic        cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] s;
  logic [31:0] r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .div_clk    (clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .cancel     (cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .s          (s),
    .r          (r)
  );

  typedef struct {
    string       nm;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] es;
    logic [31:0] er;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic start_op(input logic sg, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    chk("ready_before_op", {31'd0, div_ready}, 32'd1);
    div_signed = sg;
    x = a;
    y = b;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] so,
                        output logic [31:0] ro, output int lat);
    start_op(sg, a, b);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    so = s;
    ro = r;
  endtask

  task automatic consume;
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] gs, gr, es, er, a, b;
    logic        sg;
    int          lat;
    int          seen;

    v[0]  = '{"u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    v[1]  = '{"s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    v[2]  = '{"s_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    v[3]  = '{"s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    v[4]  = '{"u_ovfops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    v[5]  = '{"u_div0",   1'b0, 32'd123,       32'd0,         32'hFFFF_FFFF, 32'd123};
    v[6]  = '{"s_div0",   1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    v[7]  = '{"s_m100_m7",1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};
    v[8]  = '{"u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
    v[9]  = '{"u5_5",     1'b0, 32'd5,         32'd5,         32'd1,         32'd0};
    v[10] = '{"s0_m5",    1'b1, 32'd0,         32'hFFFF_FFFB, 32'd0,         32'd0};
    v[11] = '{"u3_10",    1'b0, 32'd3,         32'd10,        32'd0,         32'd3};
    v[12] = '{"u_max_max",1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0};
    v[13] = '{"s_m1_m1",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0};

    reset = 1'b1;
    div_valid = 1'b0;
    div_signed = 1'b0;
    x = '0;
    y = '0;
    cancel = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(v[i].sg, v[i].a, v[i].b, gs, gr, lat);
      chk({v[i].nm, "_s"}, gs, v[i].es);
      chk({v[i].nm, "_r"}, gr, v[i].er);
      chk({v[i].nm, "_lat"}, lat, 32'd33);
      consume;
    end

    // Backpressure: result held while res_ready stays low
    run_op(1'b0, 32'd1000, 32'd10, gs, gr, lat);
    chk("bp_s0", gs, 32'd100);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_s", s, 32'd100);
      chk("bp_r", r, 32'd0);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_ready", {31'd0, div_ready}, 32'd0);
    end
    consume;
    chk("bp_rel_ready", {31'd0, div_ready}, 32'd1);
    chk("bp_rel_valid", {31'd0, res_valid}, 32'd0);

    // Cancel mid-CALC, then a back-to-back op
    start_op(1'b0, 32'd500, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cx_ready", {31'd0, div_ready}, 32'd1);
    chk("cx_valid", {31'd0, res_valid}, 32'd0);
    chk("cx_s_kept", s, 32'd100);
    chk("cx_r_kept", r, 32'd0);
    run_op(1'b0, 32'd20, 32'd3, gs, gr, lat);
    chk("b2b_s", gs, 32'd6);
    chk("b2b_r", gr, 32'd2);
    chk("b2b_lat", lat, 32'd33);
    consume;

    // Cancel and div_valid together in IDLE: nothing accepted
    @(negedge clk);
    div_signed = 1'b0;
    x = 32'd9;
    y = 32'd3;
    div_valid = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    cancel = 1'b0;
    chk("cv_ready", {31'd0, div_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid || !div_ready) seen++;
    end
    chk("cv_no_op", seen, 32'd0);

    // Reset mid-CALC
    start_op(1'b0, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rc_ready", {31'd0, div_ready}, 32'd1);
    chk("rc_valid", {31'd0, res_valid}, 32'd0);
    chk("rc_s", s, 32'd0);
    chk("rc_r", r, 32'd0);

    // Reset while holding a result in DONE
    run_op(1'b0, 32'd77, 32'd5, gs, gr, lat);
    chk("rd_pre_s", gs, 32'd15);
    chk("rd_pre_r", gr, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rd_ready", {31'd0, div_ready}, 32'd1);
    chk("rd_valid", {31'd0, res_valid}, 32'd0);
    chk("rd_s", s, 32'd0);
    chk("rd_r", r, 32'd0);

    // Random regression against the language operators
    for (int n = 0; n < 300; n++) begin
      sg = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = -a;
      if ($urandom_range(0, 3) == 0) b = -b;
      if ($urandom_range(0, 19) == 0) b = '0;
      if (b == '0) begin
        es = '1;
        er = a;
      end else if (sg) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          es = a;
          er = '0;
        end else begin
          es = $signed(a) / $signed(b);
          er = $signed(a) % $signed(b);
        end
      end else begin
        es = a / b;
        er = a % b;
      end
      run_op(sg, a, b, gs, gr, lat);
      chk("rnd_s", gs, es);
      chk("rnd_r", gr, er);
      consume;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
